// File: rtl/button_debounce_evn.sv
// ---------------------------------------------------------------------------
// button_debounce_evn
// Input-side front end for the LIFCL-40-EVN push buttons / DIP switches.
// Each raw pin is synchronised, debounced on a prescaled tick, and reported
// as a clean level. It also produces one-cycle press/release pulses and a
// valid/ready event stream that carries the channel index and direction.
//
// Ports
//   clk        in   1     system clock (internal oscillator)
//   gsrn       in   1     asynchronous active-low reset
//   btn_n      in   N     raw asynchronous board pins
//   state      out  N     debounced level, 1 = pressed
//   press      out  N     one-cycle pulse on debounced 0->1
//   release_o  out  N     one-cycle pulse on debounced 1->0
//   ev_valid   out  1     event available
//   ev_ready   in   1     consumer accepts the event when ev_valid && ev_ready
//   ev_idx     out  IDXW  channel of the current event
//   ev_press   out  1     1 = press event, 0 = release event
//   ev_overrun out  1     sticky: an unconsumed event was overwritten
//   ov_clr     in   1     synchronous clear of ev_overrun
// ---------------------------------------------------------------------------
module button_debounce_evn #(
    parameter int N          = 8,
    parameter int TICK_DIV   = 16,
    parameter int DB_CNT     = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int IDXW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            gsrn,
    input  logic [N-1:0]    btn_n,
    output logic [N-1:0]    state,
    output logic [N-1:0]    press,
    output logic [N-1:0]    release_o,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [IDXW-1:0] ev_idx,
    output logic            ev_press,
    output logic            ev_overrun,
    input  logic            ov_clr
);

    localparam int CNTW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DB_CNT - 1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    // Synchroniser reset value is the released (idle) pin level.
    localparam logic [N-1:0] IDLE_PIN = {N{ACTIVE_LOW != 0}};

    logic [N-1:0]    sync1_q, sync2_q;
    logic [N-1:0]    s;
    logic            tick;
    logic [CNTW-1:0] cnt_q [N];
    logic [CNTW-1:0] cnt_d [N];
    logic [N-1:0]    state_q, state_d;
    logic [N-1:0]    press_q, press_d;
    logic [N-1:0]    release_q, release_d;
    logic [N-1:0]    pend_q, pend_d;
    logic [N-1:0]    dir_q, dir_d;
    logic            ev_valid_q, ev_valid_d;
    logic [IDXW-1:0] ev_idx_q, ev_idx_d;
    logic            ev_press_q, ev_press_d;
    logic            ev_overrun_q, ev_overrun_d;

    // Two-flop synchroniser; s is the "pressed" view of the pin.
    always_ff @(posedge clk or negedge gsrn) begin
        if (!gsrn) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // Debounce sample tick: free-running prescaler, tick while all-ones.
    generate
        if (TICK_DIV == 0) begin : g_nodiv
            assign tick = 1'b1;
        end else begin : g_div
            localparam logic [TICK_DIV-1:0] PRE_ONE = TICK_DIV'(1);
            logic [TICK_DIV-1:0] presc_q, presc_d;

            always_comb presc_d = presc_q + PRE_ONE;

            always_ff @(posedge clk or negedge gsrn) begin
                if (!gsrn) presc_q <= '0;
                else       presc_q <= presc_d;
            end

            assign tick = &presc_q;
        end
    endgenerate

    // Per-channel debounce: a level change needs DB_CNT consecutive
    // disagreeing ticks; any agreeing tick restarts the count.
    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (s[i] == state_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    cnt_d[i]     = '0;
                    state_d[i]   = s[i];
                    press_d[i]   = s[i];
                    release_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Event path. Candidates are already-pending channels plus edges arriving
    // this cycle, so a fresh edge reaches an empty slot without a pend stop.
    // For a pending channel the older stored event is delivered first and a
    // simultaneous new edge stays pending (set wins over load-clear).
    always_comb begin
        logic [N-1:0]    edge_now;
        logic            load;
        logic            found;
        logic [IDXW-1:0] sel_idx;
        logic            sel_dir;
        logic            taken;
        logic            ovr_new;

        edge_now = press_q | release_q;
        load     = !ev_valid_q || ev_ready;
        found    = 1'b0;
        sel_idx  = '0;
        sel_dir  = 1'b0;
        ovr_new  = 1'b0;
        pend_d   = pend_q;
        dir_d    = dir_q;

        // Ascending scan: the lowest-index candidate wins.
        for (int i = 0; i < N; i++) begin
            if ((pend_q[i] || edge_now[i]) && !found) begin
                found   = 1'b1;
                sel_idx = IDXW'(i);
                sel_dir = pend_q[i] ? dir_q[i] : state_q[i];
            end
        end

        for (int i = 0; i < N; i++) begin
            taken = load && found && (sel_idx == IDXW'(i));
            if (taken) pend_d[i] = pend_q[i] & edge_now[i];
            else       pend_d[i] = pend_q[i] | edge_now[i];
            // state_q already holds the new level while the edge pulse is high.
            if (edge_now[i]) dir_d[i] = state_q[i];
            if (edge_now[i] && pend_q[i] && !taken) ovr_new = 1'b1;
        end

        ev_valid_d = ev_valid_q;
        ev_idx_d   = ev_idx_q;
        ev_press_d = ev_press_q;
        if (load) begin
            ev_valid_d = found;
            if (found) begin
                ev_idx_d   = sel_idx;
                ev_press_d = sel_dir;
            end
        end

        // A new overrun beats a simultaneous clear.
        ev_overrun_d = (ev_overrun_q & ~ov_clr) | ovr_new;
    end

    always_ff @(posedge clk or negedge gsrn) begin
        if (!gsrn) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            state_q      <= '0;
            press_q      <= '0;
            release_q    <= '0;
            pend_q       <= '0;
            dir_q        <= '0;
            ev_valid_q   <= 1'b0;
            ev_idx_q     <= '0;
            ev_press_q   <= 1'b0;
            ev_overrun_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            state_q      <= state_d;
            press_q      <= press_d;
            release_q    <= release_d;
            pend_q       <= pend_d;
            dir_q        <= dir_d;
            ev_valid_q   <= ev_valid_d;
            ev_idx_q     <= ev_idx_d;
            ev_press_q   <= ev_press_d;
            ev_overrun_q <= ev_overrun_d;
        end
    end

    assign state      = state_q;
    assign press      = press_q;
    assign release_o  = release_q;
    assign ev_valid   = ev_valid_q;
    assign ev_idx     = ev_idx_q;
    assign ev_press   = ev_press_q;
    assign ev_overrun = ev_overrun_q;

endmodule

// File: tb/tb_button_debounce_evn.sv
module tb_button_debounce_evn;

    logic       clk = 1'b0;
    logic       gsrn = 1'b1;
    logic [7:0] btn_n = 8'hFF;
    logic [7:0] state, press, release_o;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [2:0] ev_idx;
    logic       ev_press;
    logic       ev_overrun;
    logic       ov_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int n;

    button_debounce_evn #(
        .N(8), .TICK_DIV(2), .DB_CNT(3), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .gsrn(gsrn), .btn_n(btn_n), .state(state), .press(press),
        .release_o(release_o), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_idx(ev_idx), .ev_press(ev_press), .ev_overrun(ev_overrun), .ov_clr(ov_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a debounced level; returns cycles spent.
    task automatic wait_level(input int ch, input logic lvl, input int maxc, output int cyc);
        cyc = 0;
        while (state[ch] !== lvl && cyc < maxc) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        // 1 Reset takes effect immediately, before any clock edge.
        #2 gsrn = 1'b0;
        #1;
        check("rst_state", state, 8'h00);
        check("rst_press", press, 8'h00);
        check("rst_release", release_o, 8'h00);
        check("rst_valid", ev_valid, 1'b0);
        check("rst_overrun", ev_overrun, 1'b0);
        repeat (3) step();
        gsrn = 1'b1;
        repeat (10) step();
        check("idle_state", state, 8'h00);
        check("idle_valid", ev_valid, 1'b0);

        // 2 Clean press on channel 3 with consumer ready.
        ev_ready = 1'b1;
        btn_n[3] = 1'b0;
        wait_level(3, 1'b1, 20, n);
        check("t2_state3", state[3], 1'b1);
        check("t2_latency_ok", (n <= 15), 1'b1);
        check("t2_press_pulse", press, 8'h08);
        step();
        check("t2_press_gone", press, 8'h00);
        check("t2_valid", ev_valid, 1'b1);
        check("t2_idx", ev_idx, 3'd3);
        check("t2_dir", ev_press, 1'b1);
        step();
        check("t2_consumed", ev_valid, 1'b0);
        btn_n[3] = 1'b1;
        wait_level(3, 1'b0, 20, n);
        check("t2_rel_state", state[3], 1'b0);
        check("t2_rel_pulse", release_o, 8'h08);
        step();
        check("t2_rel_valid", ev_valid, 1'b1);
        check("t2_rel_idx", ev_idx, 3'd3);
        check("t2_rel_dir", ev_press, 1'b0);
        step();
        check("t2_rel_consumed", ev_valid, 1'b0);

        // 3 Bounce: channel 0 toggles every 5 cycles, never settles long enough.
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 0) btn_n[0] = ~btn_n[0];
            step();
            check("t3_bounce_quiet",
                  {state[0], press[0], release_o[0], ev_valid}, 4'b0000);
        end
        check("t3_pin_high", btn_n[0], 1'b1);
        repeat (20) step();
        check("t3_settled", state, 8'h00);
        check("t3_no_event", ev_valid, 1'b0);

        // 4 Priority: channels 1 and 5 fall together, consumer stalled.
        ev_ready = 1'b0;
        btn_n[1] = 1'b0;
        btn_n[5] = 1'b0;
        wait_level(1, 1'b1, 20, n);
        check("t4_state", state, 8'h22);
        check("t4_press_both", press, 8'h22);
        step();
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", ev_valid, 1'b1);
            check("t4_hold_idx", ev_idx, 3'd1);
            check("t4_hold_dir", ev_press, 1'b1);
            step();
        end
        ev_ready = 1'b1;
        step();
        check("t4_second_valid", ev_valid, 1'b1);
        check("t4_second_idx", ev_idx, 3'd5);
        check("t4_second_dir", ev_press, 1'b1);
        step();
        check("t4_drained", ev_valid, 1'b0);
        btn_n[1] = 1'b1;
        btn_n[5] = 1'b1;
        wait_level(1, 1'b0, 20, n);
        check("t4_rel_state", state, 8'h00);
        step();
        check("t4_rel1_idx", ev_idx, 3'd1);
        check("t4_rel1_dir", {ev_valid, ev_press}, 2'b10);
        step();
        check("t4_rel5_idx", ev_idx, 3'd5);
        check("t4_rel5_dir", {ev_valid, ev_press}, 2'b10);
        step();
        check("t4_rel_drained", ev_valid, 1'b0);

        // 5 Overrun: ch0 held in the slot while ch2 presses and releases.
        ev_ready = 1'b0;
        btn_n[0] = 1'b0;
        wait_level(0, 1'b1, 20, n);
        step();
        check("t5_slot_valid", ev_valid, 1'b1);
        check("t5_slot_idx", ev_idx, 3'd0);
        btn_n[2] = 1'b0;
        wait_level(2, 1'b1, 20, n);
        check("t5_ch2_pressed", state[2], 1'b1);
        step();
        check("t5_no_overrun_yet", ev_overrun, 1'b0);
        btn_n[2] = 1'b1;
        wait_level(2, 1'b0, 20, n);
        check("t5_ch2_released", state[2], 1'b0);
        step();
        check("t5_overrun", ev_overrun, 1'b1);
        check("t5_slot_kept", ev_idx, 3'd0);
        ev_ready = 1'b1;
        step();
        check("t5_ch2_valid", ev_valid, 1'b1);
        check("t5_ch2_idx", ev_idx, 3'd2);
        check("t5_ch2_dir", ev_press, 1'b0);
        step();
        check("t5_once", ev_valid, 1'b0);
        step();
        check("t5_once_still", ev_valid, 1'b0);
        check("t5_overrun_sticky", ev_overrun, 1'b1);
        ov_clr = 1'b1;
        step();
        ov_clr = 1'b0;
        check("t5_overrun_clr", ev_overrun, 1'b0);

        // 6 Reset while an event is in the slot and ch4 is pending.
        ev_ready = 1'b0;
        btn_n[0] = 1'b1;
        wait_level(0, 1'b0, 20, n);
        step();
        check("t6_slot_valid", ev_valid, 1'b1);
        check("t6_slot_dir", {ev_idx, ev_press}, 4'b0000);
        btn_n[4] = 1'b0;
        wait_level(4, 1'b1, 20, n);
        check("t6_ch4_pressed", state[4], 1'b1);
        step();
        #2 gsrn = 1'b0;
        #1;
        check("t6_async_valid", ev_valid, 1'b0);
        check("t6_async_state", state, 8'h00);
        btn_n = 8'hFF;
        repeat (3) step();
        gsrn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            check("t6_quiet", {ev_valid, state}, 9'h000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
